// File: rtl/uart_pkg.sv
// Shared UART definitions: register map, bit positions, receiver states, baud divisor.
package uart_pkg;

    localparam logic [11:0] OFF_CFG    = 12'h000;
    localparam logic [11:0] OFF_DATA   = 12'h004;
    localparam logic [11:0] OFF_INST   = 12'h008;
    localparam logic [11:0] OFF_STATUS = 12'h00C;

    localparam int CFG_EN   = 0;
    localparam int CFG_BAUD = 1;
    localparam int CFG_IRQ  = 2;
    localparam int CFG_PAR  = 3;
    localparam int CFG_ODD  = 4;

    localparam int INST_FLUSH = 0;
    localparam int INST_CLR   = 1;

    localparam int ST_CNT = 8;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;

    // Clocks per bit minus one; the bit counter runs 0..DIV.
    function automatic logic [31:0] baud_div(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud - 1;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Peripheral slave bus bundle for the UART receiver.
interface uart_rx_if #(parameter int ADDR_WIDTH = 32);
    logic                  HSEL;
    logic [3:0]            HBE;
    logic                  HREADY;
    logic [ADDR_WIDTH-1:0] HADDR;
    logic                  HWRITE;
    logic [31:0]           HRDATA;
    logic [31:0]           HWDATA;

    modport master (output HSEL, HBE, HADDR, HWRITE, HWDATA, input HREADY, HRDATA);
    modport slave  (input HSEL, HBE, HADDR, HWRITE, HWDATA, output HREADY, HRDATA);
endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous byte FIFO; head byte is valid combinationally, flush has priority.
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clock,
    input  logic          nRst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  logic [7:0]    din_i,
    output logic [7:0]    dout_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] rd_q, wr_q;
    logic [CW-1:0] cnt_q;
    logic          do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rd_q];
    assign do_pop  = pop_i & ~empty_o & ~flush_i;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push_i & ~flush_i & (~full_o | do_pop);

    always_ff @(posedge clock or negedge nRst) begin
        if (!nRst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end
endmodule

// File: rtl/uart_rx.sv
// Memory-mapped 8N1 UART receiver with byte FIFO and level interrupt.
// Define UART_RX_PARITY_EN to add the optional parity bit check.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned sys_clk    = 50000000,
    parameter int          ADDR_WIDTH = 32,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic     clock,
    input  logic     nRst,
    uart_rx_if.slave bus,
    output logic     interrupt,
    input  logic     RX
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef UART_RX_PARITY_EN
    localparam int CFG_W = 5;
`else
    localparam int CFG_W = 3;
`endif
    localparam logic [31:0] DIV_FAST = baud_div(sys_clk, 115200);
    localparam logic [31:0] DIV_SLOW = baud_div(sys_clk, 9600);

    logic [CFG_W-1:0]      cfg_q;
    logic                  rx_meta_q, rx_s_q;
    rx_state_e             state_q;
    logic [31:0]           cnt_q, div, half;
    logic [2:0]            bit_q;
    logic [7:0]            shift_q;
    logic                  push_q, ferr_set_q, perr_set_q, pbad_q;
    logic                  ovr_q, frm_q, perr_q;
    logic [31:0]           rdata_d;
    logic [ADDR_WIDTH-1:0] addr;
    logic [11:0]           off;
    logic                  wr, rd, flush, clr, pop, ovr_set;
    logic [7:0]            f_dout;
    logic                  f_full, f_empty;
    logic [CW-1:0]         f_count;
    logic                  unused_bits;

    assign addr        = bus.HADDR;
    assign off         = addr[11:0];
    assign unused_bits = ^{bus.HBE, addr};
    assign wr          = bus.HSEL & bus.HWRITE;
    assign rd          = bus.HSEL & ~bus.HWRITE;
    assign flush       = wr & (off == OFF_INST) & bus.HWDATA[INST_FLUSH];
    assign clr         = wr & (off == OFF_INST) & bus.HWDATA[INST_CLR];
    assign pop         = rd & (off == OFF_DATA) & ~f_empty;
    assign ovr_set     = push_q & f_full & ~pop & ~flush;
    assign div         = cfg_q[CFG_BAUD] ? DIV_FAST : DIV_SLOW;
    assign half        = div >> 1;

    uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock   (clock),
        .nRst    (nRst),
        .push_i  (push_q),
        .pop_i   (pop),
        .flush_i (flush),
        .din_i   (shift_q),
        .dout_o  (f_dout),
        .full_o  (f_full),
        .empty_o (f_empty),
        .count_o (f_count)
    );

    always_comb begin
        rdata_d = '0;
        case (off)
            OFF_CFG:    rdata_d = 32'(cfg_q);
            OFF_DATA:   rdata_d = f_empty ? 32'd0 : {24'd0, f_dout};
            OFF_STATUS: rdata_d = (32'(f_count) << ST_CNT)
                                | 32'({perr_q, frm_q, ovr_q, f_full, ~f_empty, state_q != IDLE});
            default:    rdata_d = '0;
        endcase
    end

    // Bus, configuration, sticky flags and interrupt.
    always_ff @(posedge clock or negedge nRst) begin
        if (!nRst) begin
            bus.HREADY <= 1'b0;
            bus.HRDATA <= '0;
            interrupt  <= 1'b0;
            cfg_q      <= '0;
            ovr_q      <= 1'b0;
            frm_q      <= 1'b0;
            perr_q     <= 1'b0;
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
        end else begin
            bus.HREADY <= bus.HSEL;
            if (rd) bus.HRDATA <= rdata_d;
            if (wr && off == OFF_CFG) cfg_q <= bus.HWDATA[CFG_W-1:0];
            ovr_q     <= ovr_set    | (ovr_q  & ~clr);
            frm_q     <= ferr_set_q | (frm_q  & ~clr);
            perr_q    <= perr_set_q | (perr_q & ~clr);
            interrupt <= cfg_q[CFG_IRQ] & (~f_empty | ovr_q | frm_q | perr_q);
            rx_meta_q <= RX;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clock or negedge nRst) begin
        if (!nRst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            push_q     <= 1'b0;
            ferr_set_q <= 1'b0;
            perr_set_q <= 1'b0;
            pbad_q     <= 1'b0;
        end else begin
            push_q     <= 1'b0;
            ferr_set_q <= 1'b0;
            perr_set_q <= 1'b0;
            if (!cfg_q[CFG_EN]) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: if (!rx_s_q) begin
                        state_q <= START;
                        cnt_q   <= '0;
                    end
                    // Half-bit check rejects glitches and centres later samples.
                    START: if (cnt_q == half) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        pbad_q  <= 1'b0;
                        state_q <= rx_s_q ? IDLE : DATA;
                    end else cnt_q <= cnt_q + 32'd1;
                    DATA: if (cnt_q == div) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s_q, shift_q[7:1]};
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= cfg_q[CFG_PAR] ? PARITY : STOP;
`else
                            state_q <= STOP;
`endif
                        end
                    end else cnt_q <= cnt_q + 32'd1;
`ifdef UART_RX_PARITY_EN
                    PARITY: if (cnt_q == div) begin
                        cnt_q   <= '0;
                        state_q <= STOP;
                        if (rx_s_q != (^shift_q ^ cfg_q[CFG_ODD])) begin
                            pbad_q     <= 1'b1;
                            perr_set_q <= 1'b1;
                        end
                    end else cnt_q <= cnt_q + 32'd1;
`endif
                    STOP: if (cnt_q == div) begin
                        state_q    <= IDLE;
                        push_q     <= rx_s_q & ~pbad_q;
                        ferr_set_q <= ~rx_s_q;
                    end else cnt_q <= cnt_q + 32'd1;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: vector table, directed corner sequences, randomized frames vs a queue model.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int unsigned SYS = 1152000;
    localparam int DEPTH = 16;

    logic clock = 1'b0;
    logic nRst  = 1'b0;
    logic RX    = 1'b1;
    logic interrupt;

    uart_rx_if #(.ADDR_WIDTH(32)) bus ();

    uart_rx #(.sys_clk(SYS), .ADDR_WIDTH(32), .FIFO_DEPTH(DEPTH)) dut (
        .clock     (clock),
        .nRst      (nRst),
        .bus       (bus),
        .interrupt (interrupt),
        .RX        (RX)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference: received bytes in arrival order plus the two sticky flags.
    logic [7:0] mq[$];
    bit m_ovr = 0;
    bit m_frm = 0;

    typedef struct {
        logic [7:0]  d;
        bit          stop;
        logic [31:0] exp_data;
        bit          exp_frm;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    task automatic bus_write(input logic [11:0] a, input logic [31:0] d);
        bus.HSEL = 1'b1; bus.HWRITE = 1'b1; bus.HADDR = {20'd0, a}; bus.HWDATA = d;
        @(negedge clock);
        bus.HSEL = 1'b0; bus.HWRITE = 1'b0;
    endtask

    task automatic bus_read(input logic [11:0] a, output logic [31:0] d);
        bus.HSEL = 1'b1; bus.HWRITE = 1'b0; bus.HADDR = {20'd0, a};
        @(negedge clock);
        bus.HSEL = 1'b0;
        d = bus.HRDATA;
    endtask

    task automatic send_byte(input logic [7:0] d, input int bc, input bit stop);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            RX = f[i];
            repeat (bc) @(negedge clock);
        end
        RX = 1'b1;
        repeat (bc + 2) @(negedge clock);
    endtask

    task automatic model_frame(input logic [7:0] d, input bit stop);
        if (!stop)                 m_frm = 1;
        else if (mq.size() < DEPTH) mq.push_back(d);
        else                       m_ovr = 1;
    endtask

    function automatic logic [31:0] model_status();
        int n;
        n = mq.size();
        return (32'(n) << 8) | {27'd0, m_frm, m_ovr, n == DEPTH, n != 0, 1'b0};
    endfunction

    task automatic check_data(input string name);
        logic [31:0] r, e;
        e = (mq.size() != 0) ? {24'd0, mq.pop_front()} : 32'd0;
        bus_read(OFF_DATA, r);
        check(name, r, e);
    endtask

    task automatic check_status(input string name);
        logic [31:0] r;
        bus_read(OFF_STATUS, r);
        check(name, r, model_status());
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] r;
        vec_t vt[5];
        vt[0] = '{8'hA5, 1'b1, 32'h0000_00A5, 1'b0};
        vt[1] = '{8'h00, 1'b1, 32'h0000_0000, 1'b0};
        vt[2] = '{8'hFF, 1'b1, 32'h0000_00FF, 1'b0};
        vt[3] = '{8'h5A, 1'b0, 32'h0000_0000, 1'b1};
        vt[4] = '{8'h81, 1'b1, 32'h0000_0081, 1'b0};

        bus.HSEL = 0; bus.HWRITE = 0; bus.HADDR = '0; bus.HWDATA = '0; bus.HBE = 4'hF;
        repeat (3) @(negedge clock);
        check("rst_hready", 32'(bus.HREADY), 32'd0);
        check("rst_hrdata", bus.HRDATA, 32'd0);
        check("rst_irq", 32'(interrupt), 32'd0);
        nRst = 1'b1;
        @(negedge clock);
        check_status("rst_status");
        check("hready_after_read", 32'(bus.HREADY), 32'd1);
        bus_read(OFF_CFG, r);
        check("rst_cfg", r, 32'd0);

        // Basic frame at 10 clocks/bit, busy visible mid-frame.
        bus_write(OFF_CFG, 32'h3);
        fork
            send_byte(8'hA5, 10, 1'b1);
            begin
                repeat (50) @(negedge clock);
                bus_read(OFF_STATUS, r);
                check("busy_mid", 32'(r[0]), 32'd1);
                check("cnt_mid", 32'(r[13:8]), 32'd0);
            end
        join
        model_frame(8'hA5, 1'b1);
        check_status("status_a5");
        check_data("data_a5");
        check_status("status_a5_empty");

        // Half-bit glitch must be rejected silently.
        RX = 1'b0;
        repeat (5) @(negedge clock);
        RX = 1'b1;
        repeat (25) @(negedge clock);
        check_status("glitch_status");

        for (int i = 0; i < 5; i++) begin
            send_byte(vt[i].d, 10, vt[i].stop);
            bus_read(OFF_STATUS, r);
            check($sformatf("vec%0d_frm", i), 32'(r[4]), 32'(vt[i].exp_frm));
            bus_read(OFF_DATA, r);
            check($sformatf("vec%0d_data", i), r, vt[i].exp_data);
            bus_write(OFF_INST, 32'h2);
        end

        // Framing error with interrupt enabled, then clear.
        bus_write(OFF_CFG, 32'h7);
        send_byte(8'h42, 10, 1'b0);
        model_frame(8'h42, 1'b0);
        check_status("ferr_status");
        check("ferr_irq", 32'(interrupt), 32'd1);
        bus_write(OFF_INST, 32'h2);
        m_frm = 0;
        repeat (2) @(negedge clock);
        check("clr_irq", 32'(interrupt), 32'd0);
        check_status("clr_status");

        // Overflow: 17 bytes into 16 entries.
        bus_write(OFF_CFG, 32'h3);
        for (int i = 0; i <= 16; i++) begin
            send_byte(8'(i), 10, 1'b1);
            model_frame(8'(i), 1'b1);
        end
        check_status("ovr_status");
        for (int i = 0; i <= 16; i++) check_data($sformatf("ovr_rd%0d", i));
        bus_write(OFF_INST, 32'h2);
        m_ovr = 0;
        check_status("ovr_cleared");

        // Pop on the exact cycle the stop-bit push lands while full.
        for (int i = 0; i < 16; i++) begin
            send_byte(8'h80 + 8'(i), 10, 1'b1);
            model_frame(8'h80 + 8'(i), 1'b1);
        end
        fork
            send_byte(8'hEE, 10, 1'b1);
            begin
                repeat (98) @(negedge clock);
                bus_read(OFF_DATA, r);
            end
        join
        check("same_cycle_rd", r, {24'd0, mq.pop_front()});
        mq.push_back(8'hEE);
        check_status("same_cycle_status");
        while (mq.size() != 0) check_data("same_cycle_drain");

        // Randomized frames with interleaved reads.
        for (int i = 0; i < 24; i++) begin
            logic [7:0] d;
            bit st;
            d  = 8'($urandom);
            st = ($urandom_range(0, 5) != 0);
            send_byte(d, 10, st);
            model_frame(d, st);
            if ($urandom_range(0, 1) == 1) check_data("rnd_data");
            if (i % 4 == 3) begin
                check_status("rnd_status");
                bus_write(OFF_INST, 32'h2);
                m_ovr = 0; m_frm = 0;
            end
        end
        while (mq.size() != 0) check_data("rnd_drain");
        check_status("rnd_final");

        // Reset in the middle of a frame, then receive at 9600.
        bus_write(OFF_CFG, 32'h7);
        bus_read(OFF_CFG, r);
        check("cfg_readback", r, 32'h7);
        fork
            send_byte(8'h99, 10, 1'b1);
            begin
                repeat (40) @(negedge clock);
                nRst = 1'b0;
                repeat (2) @(negedge clock);
                check("midrst_hready", 32'(bus.HREADY), 32'd0);
                check("midrst_hrdata", bus.HRDATA, 32'd0);
                check("midrst_irq", 32'(interrupt), 32'd0);
                nRst = 1'b1;
            end
        join
        check_status("postrst_status");
        bus_write(OFF_CFG, 32'h1);
        send_byte(8'h3C, 120, 1'b1);
        model_frame(8'h3C, 1'b1);
        check_status("slow_status");
        check_data("slow_data");
        check_status("slow_empty");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Memory-mapped UART receiver; the receive-side counterpart of the team's UART transmitter.
- Deserialises 8N1 frames from the external RX pin into a small byte FIFO; the CPU reads bytes over the same slave bus.
- Sits on the peripheral bus beside the TX block; RX pin comes from the board (or, in loopback benches, a TX pin).
- Raises a level interrupt when data is waiting or an error occurred.

Parameters:
- sys_clk, 50000000, system clock frequency in Hz.
- ADDR_WIDTH, 32, bus address width (only HADDR[11:0] decoded).
- FIFO_DEPTH, 16, RX FIFO entries; power of two, 2..32.

Ports:
- clock  input  1  system clock.
- nRst  input  1  reset, asynchronous, active-low.
- HSEL  input  1  slave select.
- HBE  input  4  byte enables; ignored, all accesses full-word.
- HREADY  output  1  access complete.
- HADDR  input  32  address; offset = HADDR[11:0].
- HWRITE  input  1  1 = write, 0 = read.
- HRDATA  output  32  read data.
- HWDATA  input  32  write data.
- interrupt  output  1  level interrupt.
- RX  input  1  asynchronous serial input, idles high.

Behaviour:
- Reset: HREADY=0, HRDATA=0, interrupt=0, all registers 0, FIFO empty, FSM IDLE, sync flops=1.
- Register map:
  - 0x00 CFG (RW): bit0 enable, bit1 baud (0=9600, 1=115200), bit2 irq enable; reads {29'b0,cfg[2:0]}.
  - 0x04 DATA (RO): read returns {24'b0, head byte} and pops; empty read returns 0, no pop.
  - 0x08 INST (WO): bit0 flush FIFO, bit1 clear overrun and framing flags; reads 0.
  - 0x0C STATUS (RO): bit0 busy (FSM not IDLE), bit1 not_empty, bit2 full, bit3 overrun, bit4 frame_err, bits[13:8] count.
  - Unmapped offsets: writes ignored, reads 0.
- Bus timing:
  - HREADY is HSEL registered (1 cycle later).
  - HRDATA is registered in the cycle HSEL & !HWRITE is seen and held until the next read.
  - Writes take effect on the clock edge where HSEL & HWRITE is sampled.
- RX is passed through a 2-flop synchroniser (rx_s); the 2-cycle latency is accepted.
- Baud divisor: DIV = sys_clk/baud - 1 (32-bit); HALF = DIV>>1.
- FSM states:
  - IDLE: if enable & rx_s==0 -> START, cnt=0.
  - START: at cnt==HALF, rx_s==0 -> DATA (cnt=0, bit=0); rx_s==1 -> IDLE (glitch rejected, no flag).
  - DATA: at cnt==DIV, shift rx_s in LSB-first, cnt=0; after bit 7 -> STOP.
  - STOP: at cnt==DIV, rx_s==1 -> push byte; rx_s==0 -> frame_err=1 and byte dropped; both -> IDLE.
  - Sampling at HALF on the start bit places every later sample at bit centre.
- FIFO push when full: byte dropped, overrun=1, FIFO contents unchanged.
- Same-cycle push and pop: both performed, count unchanged, also when full.
- Flush and push in the same cycle: flush wins, FIFO empty.
- Flag set and clear in the same cycle: set wins.
- Enable cleared mid-frame: FSM -> IDLE next cycle, partial byte discarded. FIFO is kept.
- Baud change mid-frame: undefined; software must change baud only while busy=0.
- interrupt = cfg[2] & (not_empty | overrun | frame_err), registered.

Optional Feature:
- UART_RX_PARITY_EN defined:
  - CFG bit3 parity enable, bit4 odd (0 = even).
  - When enabled, FSM gains a PARITY state between DATA and STOP, sampled at cnt==DIV.
  - Mismatch sets STATUS bit5 par_err (cleared by INST bit1, included in interrupt) and drops the byte.
- Undefined: CFG bits 3/4 and STATUS bit5 read 0; no PARITY state.

Decomposition:
- Shared uart_pkg holds:
  - register offsets and CFG/INST/STATUS bit indices, shared with the TX block;
  - the rx state enum (IDLE, START, DATA, PARITY, STOP);
  - a divisor function from sys_clk and baud.
- One sub-module: uart_rx_fifo, a synchronous FIFO.
  - Ports: push, pop, flush, din[7:0], dout[7:0], full, empty, count.
  - Single-cycle flags; head data is valid combinationally.

Test Plan:
- Use sys_clk=1152000, so DIV=9 at 115200 and DIV=119 at 9600.
- CFG=0x3, drive frame 0xA5 at 10 clocks/bit -> busy high during the frame, STATUS count=1, DATA read returns 0x000000A5, then count=0.
- 0.5-bit low glitch on RX (5 clocks) -> FSM returns to IDLE, no flags set, count stays 0.
- Stop bit driven 0 with CFG=0x7 -> frame_err=1, interrupt=1, FIFO empty; INST write 0x2 -> flags clear, interrupt=0.
- Send 17 bytes 0x00..0x10 with FIFO_DEPTH=16 -> full=1, overrun=1; the reads return 0x00..0x0F; a 17th read returns 0.
- DATA read on the exact cycle a STOP push occurs, FIFO full -> push accepted, count stays 16, overrun=0.
- Assert nRst mid-DATA, then send 0x3C at 9600 (CFG=0x1) -> after reset all outputs 0; the byte is received correctly at DIV=119.
